regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port between two write-back requesters:
//  req0 (ALU result) and req1 (memory load).
//  Arbitration is round-robin with a starvation guard. The winner is registered into one
//  output stage that drives Reg_Write/Write_Register/Write_Data of the register file.
//  Sits between the execute/memory stages and the register file.
// PARAMETERS
//  N          32  data width; matches register file N
//  MAX_WAIT   4   cycles a requester may be refused while valid before it is force-granted (1..15)
//  BLOCK_R0   1   1: writes to register 0 are accepted but never issued to the register file
// PORTS
//  clk                 in   1    rising-edge clock
//  reset               in   1    asynchronous, active-low reset
//  req0_valid_i        in   1    ALU write-back request
//  req0_addr_i         in   5    ALU destination register
//  req0_data_i         in   N    ALU result
//  req0_ready_o        out  1    ALU request accepted this cycle
//  req1_valid_i        in   1    load write-back request
//  req1_addr_i         in   5    load destination register
//  req1_data_i         in   N    load data
//  req1_ready_o        out  1    load request accepted this cycle
//  Reg_Write_o         out  1    register file write enable
//  Write_Register_o    out  5    register file write address
//  Write_Data_o        out  N    register file write data
//  grant_id_o          out  1    requester of the current Reg_Write_o (0/1)
// BEHAVIOUR
//  - Reset (reset=0, async): Reg_Write_o=0, Write_Register_o=0, Write_Data_o=0, grant_id_o=0.
//    Round-robin pointer resets to "req0 first". Both wait counters reset to 0.
//  - Transfer occurs when valid_i=1 and ready_o=1 in the same cycle.
//  - ready_o is combinational from the valids, pointer and counters. A non-granted requester
//    must hold valid, addr and data stable until it is accepted.
//  - Latency: a request accepted in cycle t drives Reg_Write_o=1 with its addr/data in t+1,
//    for exactly one cycle. The register file always accepts, so there is no backpressure on
//    the output stage.
//  - Only one valid: that requester is granted the same cycle (0-cycle arbitration).
//  - Both valid: priority order, highest first:
//    (a) the requester whose wait counter == MAX_WAIT; if both, req1;
//    (b) otherwise the round-robin pointer.
//    After each grant the pointer moves to the non-granted requester.
//  - Wait counter per requester: increments when valid=1 and not granted; saturates at
//    MAX_WAIT; clears on grant or when valid=0.
//  - Pointer FSM states: PRI0 and PRI1.
//    PRI0 -> PRI1 on a grant to req0; PRI1 -> PRI0 on a grant to req1.
//    No change on idle cycles.
//  - BLOCK_R0=1 and granted addr==0: the request is accepted (ready=1). In t+1: Reg_Write_o=0,
//    Write_Register_o/Write_Data_o are don't-care, grant_id_o is updated. The pointer still advances.
//  - No valid: Reg_Write_o=0 next cycle; Write_Register_o/Write_Data_o hold their last values.
//  - Same address from both requesters in consecutive grants: both writes issue in grant
//    order; the last one wins in the register file.
//  - Reset asserted mid-transfer: an accepted write still in the output stage is dropped.
// CONFIGURATION
//  - Macro WB_BYPASS_EN.
//  - Defined: adds these ports:
//    rd1_addr_i[5], rd1_data_i[N], rd1_data_o[N]
//    rd2_addr_i[5], rd2_data_i[N], rd2_data_o[N]
//    rdX_data_i is the register file read data. rdX_data_o = Write_Data_o when Reg_Write_o=1
//    and Write_Register_o==rdX_addr_i; otherwise rdX_data_o = rdX_data_i.
//    This hides the one-cycle write-to-read hazard. Bypass never matches on r0 when BLOCK_R0=1.
//  - Undefined: the ports are absent and there is no bypass logic.
// STRUCTURE
//  - regfile_pkg: REG_ADDR_W=5, NUM_REGS=32, REQ_ALU=1'b0, REQ_MEM=1'b1,
//    pointer-state encoding (PRI0=1'b0, PRI1=1'b1).
//  - One sub-module: rr_arbiter2. It holds the pointer FSM, the wait counters and the grant logic.
//    Grant outputs are one-hot.
//  - The top level holds the output-stage registers, the r0 filter and the optional bypass.
// TESTING
//  1. Reset check: with reset=0, all outputs are 0. Release reset, then req0 only: addr=5,
//     data=0xDEADBEEF -> ready0=1 same cycle; next cycle Reg_Write_o=1, Write_Register_o=5,
//     Write_Data_o=0xDEADBEEF, grant_id_o=0.
//  2. Round-robin: both valid for 4 cycles (req0 addr=1, req1 addr=2; new data each accept)
//     -> grants in order 0,1,0,1; Reg_Write_o=1 on all 4 following cycles.
//  3. Starvation guard, MAX_WAIT=2: req0 re-asserts every cycle while req1 is held valid.
//     -> req1 is granted no later than its 3rd valid cycle; its wait counter never exceeds 2.
//  4. r0 write: req1 addr=0, data=0x1234 -> ready1=1; next cycle Reg_Write_o=0, grant_id_o=1.
//     A following req0 request is granted normally.
//  5. Reset mid-operation: accept req0 addr=7, then assert reset before the next edge
//     -> Reg_Write_o=0 immediately; no write to r7 ever issues.
//  6. WB_BYPASS_EN: accept req0 addr=3, data=0xA5A5A5A5; next cycle rd1_addr_i=3,
//     rd1_data_i=0 -> rd1_data_o=0xA5A5A5A5. Same cycle rd2_addr_i=4 -> rd2_data_o=rd2_data_i.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants, pointer-state encoding and wait-counter helper
//
// Purpose : common definitions for the register-file write-back arbiter.
// Contents: REG_ADDR_W / NUM_REGS register-file geometry, requester ids
//           (REQ_ALU = req0, REQ_MEM = req1), round-robin pointer states
//           PRI0 / PRI1, and the saturating wait-counter update function.
package regfile_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  // Wait counters must hold MAX_WAIT values up to 15.
  localparam int WAIT_W = 4;

  localparam logic REQ_ALU = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } rr_state_e;

  // A requester's wait count only grows while it is valid and refused;
  // any grant or a dropped request restarts it from zero.
  function automatic logic [WAIT_W-1:0] wait_next(
    input logic              valid,
    input logic              granted,
    input logic [WAIT_W-1:0] cnt,
    input logic [WAIT_W-1:0] max_wait
  );
    if (!valid || granted) return '0;
    if (cnt >= max_wait)   return max_wait;
    return cnt + 4'd1;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// rtl/regfile_wb_arbiter_if.sv - write-back request / register-file write bundle
//
// Purpose : groups the two write-back request channels, the register-file
//           write port and (with WB_BYPASS_EN) the read-bypass signals.
// Modports: master - requester/register-file side (drives requests, sees writes)
//           slave  - the arbiter
// Signals : reqX_valid_i/addr_i/data_i/ready_o for X = 0 (ALU), 1 (load);
//           Reg_Write_o, Write_Register_o, Write_Data_o, grant_id_o;
//           rdX_addr_i/rdX_data_i/rdX_data_o for X = 1, 2 when WB_BYPASS_EN.
// Macro   : WB_BYPASS_EN adds the bypass read signals.
interface regfile_wb_arbiter_if #(
  parameter int N = 32
);
  import regfile_pkg::*;

  logic                  req0_valid_i;
  logic [REG_ADDR_W-1:0] req0_addr_i;
  logic [N-1:0]          req0_data_i;
  logic                  req0_ready_o;

  logic                  req1_valid_i;
  logic [REG_ADDR_W-1:0] req1_addr_i;
  logic [N-1:0]          req1_data_i;
  logic                  req1_ready_o;

  logic                  Reg_Write_o;
  logic [REG_ADDR_W-1:0] Write_Register_o;
  logic [N-1:0]          Write_Data_o;
  logic                  grant_id_o;

`ifdef WB_BYPASS_EN
  logic [REG_ADDR_W-1:0] rd1_addr_i;
  logic [N-1:0]          rd1_data_i;
  logic [N-1:0]          rd1_data_o;
  logic [REG_ADDR_W-1:0] rd2_addr_i;
  logic [N-1:0]          rd2_data_i;
  logic [N-1:0]          rd2_data_o;

  modport master (
    output req0_valid_i, req0_addr_i, req0_data_i,
    input  req0_ready_o,
    output req1_valid_i, req1_addr_i, req1_data_i,
    input  req1_ready_o,
    input  Reg_Write_o, Write_Register_o, Write_Data_o, grant_id_o,
    output rd1_addr_i, rd1_data_i, rd2_addr_i, rd2_data_i,
    input  rd1_data_o, rd2_data_o
  );

  modport slave (
    input  req0_valid_i, req0_addr_i, req0_data_i,
    output req0_ready_o,
    input  req1_valid_i, req1_addr_i, req1_data_i,
    output req1_ready_o,
    output Reg_Write_o, Write_Register_o, Write_Data_o, grant_id_o,
    input  rd1_addr_i, rd1_data_i, rd2_addr_i, rd2_data_i,
    output rd1_data_o, rd2_data_o
  );
`else
  modport master (
    output req0_valid_i, req0_addr_i, req0_data_i,
    input  req0_ready_o,
    output req1_valid_i, req1_addr_i, req1_data_i,
    input  req1_ready_o,
    input  Reg_Write_o, Write_Register_o, Write_Data_o, grant_id_o
  );

  modport slave (
    input  req0_valid_i, req0_addr_i, req0_data_i,
    output req0_ready_o,
    input  req1_valid_i, req1_addr_i, req1_data_i,
    output req1_ready_o,
    output Reg_Write_o, Write_Register_o, Write_Data_o, grant_id_o
  );
`endif

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// rtl/regfile_wb_arbiter_rr_arbiter2.sv - two-way round-robin arbiter with starvation guard
//
// Purpose : picks one of two valid requesters each cycle; grant is one-hot
//           and combinational from the valids, pointer and wait counters.
// Ports   : clk    in  rising-edge clock
//           reset  in  asynchronous active-low reset
//           valid  in  [1:0] request valids (bit 0 = req0, bit 1 = req1)
//           grant  out [1:0] one-hot grant, all-zero when nothing is valid
module rr_arbiter2
  import regfile_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  localparam logic [WAIT_W-1:0] MAX_W = WAIT_W'(MAX_WAIT);

  rr_state_e         state, state_next;
  logic [WAIT_W-1:0] wait0, wait1;
  logic [WAIT_W-1:0] wait0_next, wait1_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= PRI0;
      wait0 <= '0;
      wait1 <= '0;
    end else begin
      state <= state_next;
      wait0 <= wait0_next;
      wait1 <= wait1_next;
    end
  end

  always_comb begin
    grant      = 2'b00;
    state_next = state;

    if (valid[0] && valid[1]) begin
      // A starved requester overrides the pointer; req1 wins a double starve.
      if (wait1 == MAX_W) begin
        grant = 2'b10;
      end else if (wait0 == MAX_W) begin
        grant = 2'b01;
      end else if (state == PRI0) begin
        grant = 2'b01;
      end else begin
        grant = 2'b10;
      end
    end else if (valid[0]) begin
      grant = 2'b01;
    end else if (valid[1]) begin
      grant = 2'b10;
    end

    // Pointer always moves to the requester that just lost (or was absent).
    if (grant[REQ_ALU]) begin
      state_next = PRI1;
    end else if (grant[REQ_MEM]) begin
      state_next = PRI0;
    end

    wait0_next = wait_next(valid[0], grant[0], wait0, MAX_W);
    wait1_next = wait_next(valid[1], grant[1], wait1, MAX_W);
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - shares the register-file write port between ALU and load write-back
//
// Purpose : arbitrates req0 (ALU) and req1 (load) onto the single register-file
//           write port through one registered output stage; optionally filters
//           writes to r0 and bypasses the in-flight write onto two read ports.
// Ports   : clk    in  rising-edge clock
//           reset  in  asynchronous active-low reset
//           bus    regfile_wb_arbiter_if.slave - request channels, register-file
//                  write port, and bypass read ports when WB_BYPASS_EN is defined
// Params  : N (data width), MAX_WAIT (refusals before force-grant, 1..15),
//           BLOCK_R0 (1: r0 writes are accepted but never issued)
// Macro   : WB_BYPASS_EN enables the read-bypass logic.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int N        = 32,
  parameter int MAX_WAIT = 4,
  parameter int BLOCK_R0 = 1
) (
  input logic                 clk,
  input logic                 reset,
  regfile_wb_arbiter_if.slave bus
);

  logic [1:0]            valid;
  logic [1:0]            grant;
  logic [REG_ADDR_W-1:0] win_addr;
  logic [N-1:0]          win_data;
  logic                  win_blocked;

  logic                  reg_write;
  logic [REG_ADDR_W-1:0] write_register;
  logic [N-1:0]          write_data;
  logic                  grant_id;

  assign valid = {bus.req1_valid_i, bus.req0_valid_i};

  rr_arbiter2 #(
    .MAX_WAIT(MAX_WAIT)
  ) u_arb (
    .clk  (clk),
    .reset(reset),
    .valid(valid),
    .grant(grant)
  );

  assign bus.req0_ready_o = grant[REQ_ALU];
  assign bus.req1_ready_o = grant[REQ_MEM];

  always_comb begin
    win_addr    = bus.req0_addr_i;
    win_data    = bus.req0_data_i;
    if (grant[REQ_MEM]) begin
      win_addr = bus.req1_addr_i;
      win_data = bus.req1_data_i;
    end
    win_blocked = (BLOCK_R0 != 0) && (win_addr == '0);
  end

  // Output stage: a write enable lasts exactly one cycle; address/data hold
  // between writes (an r0 drop leaves them untouched too).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_write      <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
      grant_id       <= 1'b0;
    end else begin
      reg_write <= 1'b0;
      if (|grant) begin
        grant_id <= grant[REQ_MEM];
        if (!win_blocked) begin
          reg_write      <= 1'b1;
          write_register <= win_addr;
          write_data     <= win_data;
        end
      end
    end
  end

  assign bus.Reg_Write_o      = reg_write;
  assign bus.Write_Register_o = write_register;
  assign bus.Write_Data_o     = write_data;
  assign bus.grant_id_o       = grant_id;

`ifdef WB_BYPASS_EN
  logic rd1_hit;
  logic rd2_hit;

  // The register file only sees the write at the next edge; forward it now.
  assign rd1_hit = reg_write && (write_register == bus.rd1_addr_i) &&
                   !((BLOCK_R0 != 0) && (bus.rd1_addr_i == '0));
  assign rd2_hit = reg_write && (write_register == bus.rd2_addr_i) &&
                   !((BLOCK_R0 != 0) && (bus.rd2_addr_i == '0));

  assign bus.rd1_data_o = rd1_hit ? write_data : bus.rd1_data_i;
  assign bus.rd2_data_o = rd2_hit ? write_data : bus.rd2_data_i;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for the write-back arbiter
`timescale 1ns/1ps
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int N        = 32;
  localparam int MAX_WAIT = 2;
  localparam int BLOCK_R0 = 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  regfile_wb_arbiter_if #(.N(N)) bus ();

  regfile_wb_arbiter #(
    .N(N), .MAX_WAIT(MAX_WAIT), .BLOCK_R0(BLOCK_R0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        gid;
    logic        known;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: who gets the port and what the register file sees next.
  int          m_ptr;
  int          m_wait[2];
  int          streak[2];
  logic        m_gid;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_known;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr     = 0;
    m_wait[0] = 0;
    m_wait[1] = 0;
    streak[0] = 0;
    streak[1] = 0;
    m_gid     = 1'b0;
    m_addr    = '0;
    m_data    = '0;
    m_known   = 1'b1;
  endtask

  // One bus cycle: drive, check readys against the model, queue the
  // expected register-file view for the next cycle.
  task automatic step(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                      input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                      output logic acc0, output logic acc1);
    int   g;
    exp_t e;
    logic [4:0]  ga;
    logic [31:0] gd;
    @(negedge clk);
    bus.req0_valid_i = v0; bus.req0_addr_i = a0; bus.req0_data_i = d0;
    bus.req1_valid_i = v1; bus.req1_addr_i = a1; bus.req1_data_i = d1;
    #1;
    if (v0 && v1) begin
      if (m_wait[1] == MAX_WAIT)      g = 1;
      else if (m_wait[0] == MAX_WAIT) g = 0;
      else                            g = m_ptr;
    end else if (v0) g = 0;
    else if (v1)     g = 1;
    else             g = -1;

    check("ready0", 32'(bus.req0_ready_o), 32'(g == 0));
    check("ready1", 32'(bus.req1_ready_o), 32'(g == 1));

    streak[0] = (v0 && !bus.req0_ready_o) ? streak[0] + 1 : 0;
    streak[1] = (v1 && !bus.req1_ready_o) ? streak[1] + 1 : 0;
    if (v0 && v1) begin
      check("refusals0_bound", 32'(streak[0] <= MAX_WAIT), 32'd1);
      check("refusals1_bound", 32'(streak[1] <= MAX_WAIT), 32'd1);
    end

    m_wait[0] = (v0 && g != 0) ? ((m_wait[0] < MAX_WAIT) ? m_wait[0] + 1 : MAX_WAIT) : 0;
    m_wait[1] = (v1 && g != 1) ? ((m_wait[1] < MAX_WAIT) ? m_wait[1] + 1 : MAX_WAIT) : 0;

    e.we = 1'b0;
    if (g >= 0) begin
      m_ptr = 1 - g;
      m_gid = (g == 1);
      ga = (g == 1) ? a1 : a0;
      gd = (g == 1) ? d1 : d0;
      if (BLOCK_R0 != 0 && ga == 5'd0) begin
        m_known = 1'b0;
      end else begin
        e.we    = 1'b1;
        m_addr  = ga;
        m_data  = gd;
        m_known = 1'b1;
      end
    end
    e.addr  = m_addr;
    e.data  = m_data;
    e.gid   = m_gid;
    e.known = m_known;
    exp_q.push_back(e);
    acc0 = (g == 0);
    acc1 = (g == 1);
  endtask

  // Monitor: compares the registered write port against the queued model view.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("Reg_Write_o", 32'(bus.Reg_Write_o), 32'(e.we));
      check("grant_id_o", 32'(bus.grant_id_o), 32'(e.gid));
      if (e.known) begin
        check("Write_Register_o", 32'(bus.Write_Register_o), 32'(e.addr));
        check("Write_Data_o", bus.Write_Data_o, e.data);
      end
    end
  end

  initial begin
    logic        a0, a1;
    logic        p0_v, p1_v;
    logic [4:0]  p0_a, p1_a;
    logic [31:0] p0_d, p1_d, d0, d1;
    int          wait_cnt;

    bus.req0_valid_i = 1'b0; bus.req0_addr_i = '0; bus.req0_data_i = '0;
    bus.req1_valid_i = 1'b0; bus.req1_addr_i = '0; bus.req1_data_i = '0;
`ifdef WB_BYPASS_EN
    bus.rd1_addr_i = '0; bus.rd1_data_i = '0;
    bus.rd2_addr_i = '0; bus.rd2_data_i = '0;
`endif
    model_reset();

    // Reset state
    #12;
    check("rst_Reg_Write_o", 32'(bus.Reg_Write_o), 32'd0);
    check("rst_Write_Register_o", 32'(bus.Write_Register_o), 32'd0);
    check("rst_Write_Data_o", bus.Write_Data_o, 32'd0);
    check("rst_grant_id_o", 32'(bus.grant_id_o), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single requester, zero-cycle grant
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, a0, a1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a0, a1);

    // Round robin, both valid
    d0 = $urandom; d1 = $urandom;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 5'd1, d0, 1'b1, 5'd2, d1, a0, a1);
      if (a0) d0 = $urandom;
      if (a1) d1 = $urandom;
    end

    // req1 held while req0 re-asserts every cycle
    p0_a = 5'd6;
    for (int i = 0; i < 6; i++) begin
      step(1'b1, p0_a, d0, 1'b1, 5'd9, d1, a0, a1);
      if (a0) begin d0 = $urandom; p0_a = 5'($urandom_range(1, 31)); end
      if (a1) d1 = $urandom;
    end

    // r0 write is swallowed, then a normal req0 write
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h1234, a0, a1);
    step(1'b1, 5'd12, 32'hCAFE0001, 1'b0, 5'd0, 32'd0, a0, a1);

    // Randomized traffic honouring the hold-until-accepted rule
    p0_v = 1'b0; p1_v = 1'b0;
    p0_a = '0; p1_a = '0; p0_d = '0; p1_d = '0;
    for (int i = 0; i < 300; i++) begin
      if (!p0_v) begin
        p0_v = ($urandom_range(0, 2) != 0);
        p0_a = 5'($urandom_range(0, 31));
        p0_d = $urandom;
      end
      if (!p1_v) begin
        p1_v = ($urandom_range(0, 2) != 0);
        p1_a = 5'($urandom_range(0, 31));
        p1_d = $urandom;
      end
      step(p0_v, p0_a, p0_d, p1_v, p1_a, p1_d, a0, a1);
      if (a0) p0_v = 1'b0;
      if (a1) p1_v = 1'b0;
    end
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a0, a1);

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    #3;
    check("queue_drained_pre_reset", 32'(exp_q.size()), 32'd0);

    // Reset between acceptance and the output edge: the r7 write never issues
    @(negedge clk);
    bus.req0_valid_i = 1'b1; bus.req0_addr_i = 5'd7; bus.req0_data_i = 32'h77777777;
    #1;
    check("r7_ready0", 32'(bus.req0_ready_o), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("r7_rst_Reg_Write_o", 32'(bus.Reg_Write_o), 32'd0);
    @(posedge clk);
    #1;
    check("r7_held_Reg_Write_o", 32'(bus.Reg_Write_o), 32'd0);
    check("r7_held_Write_Register_o", 32'(bus.Write_Register_o), 32'd0);
    @(negedge clk);
    bus.req0_valid_i = 1'b0;
    reset = 1'b1;
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a0, a1);

    // Reset while a write sits in the output stage drops it at once
    step(1'b1, 5'd11, 32'h0B0B0B0B, 1'b0, 5'd0, 32'd0, a0, a1);
    @(posedge clk);
    #2;
    check("stage_Reg_Write_o", 32'(bus.Reg_Write_o), 32'd1);
    reset = 1'b0;
    #1;
    check("stage_rst_Reg_Write_o", 32'(bus.Reg_Write_o), 32'd0);
    check("stage_rst_Write_Data_o", bus.Write_Data_o, 32'd0);
    @(negedge clk);
    bus.req0_valid_i = 1'b0;
    reset = 1'b1;
    model_reset();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a0, a1);

`ifdef WB_BYPASS_EN
    step(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 32'd0, a0, a1);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, a0, a1);
    bus.rd1_addr_i = 5'd3; bus.rd1_data_i = 32'd0;
    bus.rd2_addr_i = 5'd4; bus.rd2_data_i = 32'h13572468;
    #1;
    check("bypass_rd1", bus.rd1_data_o, 32'hA5A5A5A5);
    check("bypass_rd2", bus.rd2_data_o, 32'h13572468);
`endif

    wait_cnt = 0;
    while (exp_q.size() > 0 && wait_cnt < 20) begin
      @(posedge clk);
      wait_cnt++;
    end
    #3;
    check("queue_drained_end", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
